// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/sub sequencer:
// state encoding and an index-width helper.
package wide_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold an index 0..n-1 (at least 1).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// ParamAdder: purely combinational N-bit adder with carry in/out,
// shared by the wide sequencer for one chunk per cycle.
module ParamAdder #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign s    = full[N-1:0];
    assign cout = full[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// Chunk-serial wide adder/subtractor: drives one shared ParamAdder
// LSB chunk first, rippling the carry through a register.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int N     = 5,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               cout
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;

    logic [N-1:0]    add_a;
    logic [N-1:0]    add_b;
    logic [N-1:0]    add_s;
    logic            add_co;
    logic            accept;

    assign accept = start && ((state == IDLE) || (state == DONE));

    assign add_a = a_reg[int'(idx)*N +: N];
    assign add_b = b_reg[int'(idx)*N +: N];

    ParamAdder #(
        .N(N)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (idx == LAST) state_n = DONE;
            DONE: state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_reg   <= a;
                // Subtract as a + ~b + 1.
                b_reg   <= sub ? ~b : b;
                carry   <= sub ? 1'b1 : cin;
                idx     <= '0;
                sum_reg <= '0;
            end else if (state == RUN) begin
                sum_reg[int'(idx)*N +: N] <= add_s;
                carry <= add_co;
                if (idx != LAST) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_reg;
    assign cout = carry;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that adds or subtracts two WORDS*N-bit operands using a single shared N-bit ParamAdder instance.
- Processes one N-bit chunk per clock, LSB chunk first, chaining the adder's cout into the next chunk's cin through a carry register.
- Sits between a requesting datapath and the ParamAdder; it is the sequencer that lets a narrow adder serve wide operands.

Parameters:
- N, 5, chunk width; passed to ParamAdder.
- WORDS, 4, number of chunks; total operand width W = N*WORDS; WORDS >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- sub  input  1  0 = a+b+cin, 1 = a-b (two's complement)
- cin  input  1  carry-in for add; ignored when sub=1
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- busy  output  1  high while chunks are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  W  result; held stable from done until the next accepted start
- cout  output  1  final carry (for sub, 1 = no borrow)

Behaviour:
- Reset: asynchronous and active-low. Reset value of every output is 0: busy=0, done=0, sum=0, cout=0. State=IDLE, idx=0, carry register=0, operand registers=0.
- States and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: stays in RUN while idx < WORDS-1; moves to DONE on the edge that processes chunk WORDS-1.
  - DONE: start=1 -> RUN; otherwise -> IDLE.
- Accepted start (state IDLE or DONE at the clock edge):
  - a_reg <= a; b_reg <= (sub ? ~b : b).
  - carry <= (sub ? 1 : cin).
  - idx <= 0; sum register cleared to 0.
- RUN, each edge:
  - ParamAdder inputs are a_reg[idx*N +: N], b_reg[idx*N +: N] and carry.
  - sum[idx*N +: N] <= s; carry <= adder cout; idx <= idx+1.
- Outputs by state:
  - busy = (state==RUN).
  - done = (state==DONE).
  - cout output = carry register, valid when done=1.
- Latency: start accepted at edge k; chunks are written at edges k+1 .. k+WORDS; done is high during the cycle following edge k+WORDS. Back-to-back: start during DONE is accepted, so a new operation begins with no idle gap.
- Ignored inputs:
  - start while busy is ignored.
  - Changes to a, b, sub or cin after acceptance do not affect the result.
- Width and overflow: idx is clog2(WORDS) bits and never exceeds WORDS-1. No signed-overflow flag; the caller derives it from the MSBs if needed.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. The partial result is discarded and no done pulse is produced.
- ParamAdder is purely combinational, so the chunk result is registered in the same cycle its inputs are presented.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 helper for the idx width.
- Sub-module: exactly one existing ParamAdder #(N) instance. The remaining control FSM, counter and registers stay in this module, as it is too small to split further.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> busy=0, done=0, sum=20'h00000, cout=0. No done pulse after release without start.
- Full carry ripple: a=20'h00001, b=20'hFFFFF, cin=0, sub=0, one start pulse -> busy for exactly 4 cycles, then done=1 for 1 cycle with sum=20'h00000, cout=1.
- Add with cin: a=20'h12345, b=20'h0ABCD, cin=1 -> done with sum=20'h1CF13, cout=0. sum remains 20'h1CF13 in IDLE until the next start.
- Subtract with borrow: a=20'h00005, b=20'h00007, sub=1, cin=1 -> sum=20'hFFFFE, cout=0.
- Subtract without borrow: a=20'h00007, b=20'h00005, sub=1, cin=0 -> sum=20'h00002, cout=1 (cin ignored).
- Interference: pulse start again and change a/b to 20'hFFFFF during RUN -> the in-flight result is unaffected.
- Reset mid-RUN: pulse rst_n low at the second RUN cycle -> outputs clear immediately, no done pulse.
- Back-to-back: assert start in the DONE cycle -> a new run begins with no idle gap and produces its own correct result.
